gate_mux_pipe: RTL
==================

Name: gate_mux_pipe

Overview:
- Parametrised successor to the flat gate-plus-MUX netlist blocks in the tech-mapping regression set.
- N = 2^SEL_BITS leaf lanes; each lane applies a per-lane 2-input gate op to its WIDTH-bit operands.
- Lane results feed a binary MUX tree selected by `sel`, optionally registered at every tree level.
- Valid/ready handshake at both ends with global stall; serves as a sequential, width/depth-scalable mapping target.

Parameters:
- WIDTH, 1, data bits per lane and of `y`; legal range 1..64.
- SEL_BITS, 2, select width; N = 2^SEL_BITS lanes; legal range 1..6.
- PIPELINE, 1, 1 = register after leaf stage and after every tree level; 0 = leaf ops and tree combinational, single output register.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts beat this cycle.
- a  input  N*WIDTH  lane k operand A at bits [k*WIDTH +: WIDTH].
- b  input  N*WIDTH  lane k operand B, same packing.
- op  input  N*3  lane k opcode at bits [k*3 +: 3].
- sel  input  SEL_BITS  selected lane index.
- out_valid  output  1  `y` holds a result.
- out_ready  input  1  consumer accepts `y`.
- y  output  WIDTH  selected lane result.

Behaviour:
- Opcodes, bitwise per lane: 0 A; 1 ~A; 2 A&B; 3 ~(A|B); 4 A^B; 5 A|B; 6 ~(A&B); 7 ~(A^B).
- Tree ordering: level i (i = 0..SEL_BITS-1) uses sel[i].
  - sel[i]=0 selects the even-indexed input (node 2k); 1 selects the odd (2k+1).
  - Net result: y = lane[sel], unsigned index.
- Global advance enable: en = !out_valid || out_ready. in_ready = en, combinational from out_ready and out_valid. No combinational path from in_valid to in_ready.
- PIPELINE=1:
  - Stage 0 registers all N lane results, the remaining select bits and a valid bit.
  - Stage j (1..SEL_BITS) registers level j-1 MUX outputs; the sel bits still needed travel with the data.
  - Final stage drives y/out_valid.
  - Latency SEL_BITS+1 cycles from accepted beat to out_valid, with no stall. Throughput 1 beat/cycle.
- PIPELINE=0: one register stage; latency 1 cycle; throughput 1 beat/cycle.
- Every stage loads when en=1. A stage's valid bit loads the upstream valid (in_valid at stage 0). Nothing loads when en=0; all stages hold.
- Bubbles are not collapsed: a stall freezes the whole pipe, including empty stages.
- Beat accepted iff in_valid && in_ready. Output beat consumed iff out_valid && out_ready.
- in_valid while in_ready=0: beat not taken; source must hold it.
- in_valid=0 while en=1: a bubble (valid=0) enters; data registers may load but are don't-care.
- Reset:
  - Every valid bit is 0, every data and sel register is 0, so y=0 and out_valid=0.
  - in_ready=1 during and after reset (out_valid=0).
  - rst wins over en. Asserting rst mid-operation discards all in-flight beats; nothing emerges afterward.
- Ordering: beats leave strictly in acceptance order; no beat is dropped or duplicated across any stall pattern.
- Simultaneous accept and consume in the same cycle is legal and sustains full throughput.

Test Plan:
- Reset/idle: assert rst 2 cycles with in_valid=1 -> out_valid=0, y=0, in_ready=1 throughout; no output beat emerges afterward.
- Op coverage (WIDTH=4, SEL_BITS=2, PIPELINE=1): A=4'b1100, B=4'b1010, sel=k, lane k op cycled 0..7 -> y = 1100, 0011, 1000, 0001, 0110, 1110, 0111, 1001, each exactly 3 cycles after accept.
- Select sweep: lanes 0..3 set to op=0 with A=1,2,3,4; sel stepped 0..3 on consecutive cycles, out_ready=1 -> y sequence 1,2,3,4 on 4 consecutive cycles, first 3 cycles after the first accept.
- Backpressure: stream 6 beats with out_ready toggling 1,0,0,1,0,1... -> in_ready low exactly while out_valid=1 and out_ready=0; output sequence identical to input order, no loss or duplication.
- Reset mid-flight: accept 3 beats, assert rst one cycle after the third -> out_valid=0 the cycle after rst; none of the 3 beats ever appear.
- PIPELINE=0, SEL_BITS=3: lane 5 op=4, A=1, B=1, sel=5 -> y=0, out_valid 1 cycle after accept; sel=7 with lane 7 op=1, A=0 -> y=1.

Source files
------------

// File: rtl/gate_mux_pipe_if.sv
// Handshake and operand bus between a beat source and gate_mux_pipe.
interface gate_mux_pipe_if #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned SEL_BITS = 2
);
  localparam int unsigned N = 1 << SEL_BITS;

  logic                  in_valid;
  logic                  in_ready;
  logic [N*WIDTH-1:0]    a;
  logic [N*WIDTH-1:0]    b;
  logic [N*3-1:0]        op;
  logic [SEL_BITS-1:0]   sel;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      y;

  // Beat source and result consumer side
  modport master (
    output in_valid, a, b, op, sel, out_ready,
    input  in_ready, out_valid, y
  );

  // Pipeline side
  modport slave (
    input  in_valid, a, b, op, sel, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/gate_mux_pipe.sv
// Per-lane 2-input gate ops feeding a binary MUX tree, optionally registered per level.
module gate_mux_pipe #(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned SEL_BITS = 2,
  parameter int unsigned PIPELINE = 1
) (
  input logic           clk,
  input logic           rst,
  gate_mux_pipe_if.slave bus
);
  localparam int unsigned N = 1 << SEL_BITS;

  logic             en;
  logic [WIDTH-1:0] lane [N];

  function automatic logic [WIDTH-1:0] gate_op(input logic [2:0] o,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] z);
    logic [WIDTH-1:0] r;
    case (o)
      3'd0:    r = x;
      3'd1:    r = ~x;
      3'd2:    r = x & z;
      3'd3:    r = ~(x | z);
      3'd4:    r = x ^ z;
      3'd5:    r = x | z;
      3'd6:    r = ~(x & z);
      default: r = ~(x ^ z);
    endcase
    return r;
  endfunction

  // Whole pipe advances together; a stall freezes every stage including bubbles
  assign en           = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = en;

  // Leaf gate results for every lane
  always_comb begin
    for (int k = 0; k < int'(N); k++) begin
      lane[k] = gate_op(bus.op[k*3 +: 3], bus.a[k*WIDTH +: WIDTH], bus.b[k*WIDTH +: WIDTH]);
    end
  end

  if (PIPELINE != 0) begin : g_pipe
    // Stage j holds N>>j values; stage 0 is the leaf register, the last one drives y
    for (genvar j = 0; j <= int'(SEL_BITS); j++) begin : g_stg
      localparam int unsigned CNT = N >> j;
      logic [WIDTH-1:0] dat [CNT];
      logic             vld;

      if (j == 0) begin : g_ld
        // Capture lane results and the incoming valid
        always_ff @(posedge clk) begin
          if (rst) begin
            vld <= 1'b0;
            for (int k = 0; k < int'(CNT); k++) dat[k] <= '0;
          end else if (en) begin
            vld <= bus.in_valid;
            for (int k = 0; k < int'(CNT); k++) dat[k] <= lane[k];
          end
        end
      end else begin : g_ld
        // One MUX tree level steered by the lowest select bit still travelling
        always_ff @(posedge clk) begin
          if (rst) begin
            vld <= 1'b0;
            for (int k = 0; k < int'(CNT); k++) dat[k] <= '0;
          end else if (en) begin
            vld <= g_stg[j-1].vld;
            for (int k = 0; k < int'(CNT); k++) begin
              dat[k] <= g_stg[j-1].g_sel.sel_r[0] ? g_stg[j-1].dat[2*k+1]
                                                  : g_stg[j-1].dat[2*k];
            end
          end
        end
      end

      if (j < int'(SEL_BITS)) begin : g_sel
        logic [SEL_BITS-j-1:0] sel_r;
        if (j == 0) begin : g_first
          // Full select enters with the leaf results
          always_ff @(posedge clk) begin
            if (rst)     sel_r <= '0;
            else if (en) sel_r <= bus.sel;
          end
        end else begin : g_rest
          // Drop the bit consumed by the previous level
          always_ff @(posedge clk) begin
            if (rst)     sel_r <= '0;
            else if (en) sel_r <= g_stg[j-1].g_sel.sel_r[SEL_BITS-j:1];
          end
        end
      end
    end

    assign bus.y         = g_stg[SEL_BITS].dat[0];
    assign bus.out_valid = g_stg[SEL_BITS].vld;
  end else begin : g_flat
    logic [WIDTH-1:0] y_r;
    logic             vld_r;

    // Combinational leaf and tree, single output register
    always_ff @(posedge clk) begin
      if (rst) begin
        y_r   <= '0;
        vld_r <= 1'b0;
      end else if (en) begin
        y_r   <= lane[bus.sel];
        vld_r <= bus.in_valid;
      end
    end

    assign bus.y         = y_r;
    assign bus.out_valid = vld_r;
  end
endmodule
